eth_frame_rx: RTL and testbench
===============================

ETH_FRAME_RX -- requirements
Module: eth_frame_rx

Interface
REQ-001 SHALL have parameter MAX_FRAME, default 1518, max bytes dst_mac..FCS inclusive.
REQ-002 SHALL have parameter PROMISC, default 0, 1 = accept any dst_mac.
REQ-003 SHALL use one clock and a synchronous active-high reset: s_axis_aclk, s_axis_areset.
REQ-004 s_axis_aclk  in  1  clock.
REQ-005 s_axis_areset  in  1  synchronous, active-high reset.
REQ-006 local_mac  in  48  station address, quasi-static.
REQ-007 s_axis_tdata  in  8  line byte (preamble, SFD, header, payload, FCS).
REQ-008 s_axis_tvalid  in  1  high for every byte of a frame; low = inter-frame gap.
REQ-009 m_axis_tdata  out  8  payload byte.
REQ-010 m_axis_tvalid  out  1  payload byte valid; no backpressure.
REQ-011 m_axis_tlast  out  1  last payload byte.
REQ-012 m_axis_tuser  out  1  on tlast beat: 1 = frame bad (CRC or oversize).
REQ-013 hdr_dst_mac / hdr_src_mac / hdr_eth_type  out  48/48/16  captured header, held until next hdr_valid.
REQ-014 hdr_valid  out  1  one-cycle pulse on acceptance of a header.
REQ-015 crc_err  out  1  one-cycle pulse with a bad tlast beat.

Function
REQ-016 States: DROP, IDLE, PREAMBLE, HEADER, PAYLOAD; all inputs sampled only on tvalid=1, except for gap detection.
REQ-017 DROP -> IDLE on the first cycle with tvalid=0; no output in DROP.
REQ-018 IDLE: tvalid=1 and byte 0x55 -> PREAMBLE with count=1; any other valid byte -> DROP.
REQ-019 PREAMBLE: 0x55 increments count (saturating at 7); 0xD5 with count>=6 -> HEADER; 0xD5 with count<6, any other byte, or tvalid=0 -> DROP (or IDLE if tvalid=0).
REQ-020 HEADER: 14 bytes, MSB-first into dst(6), src(6), type(2); tvalid=0 before byte 14 -> IDLE, no outputs.
REQ-021 After byte 14: dst==local_mac, dst==FF:FF:FF:FF:FF:FF, or PROMISC=1 -> hdr regs updated, hdr_valid pulsed next cycle, PAYLOAD; otherwise hdr regs unchanged -> DROP.
REQ-022 PAYLOAD: bytes pushed into a 5-entry delay line; a push while holding 5 emits the oldest byte next cycle with tlast=0, tuser=0.
REQ-023 PAYLOAD end (tvalid=0) with 5 held: next cycle emits the oldest with tlast=1, tuser=crc_bad, crc_err=crc_bad; the remaining 4 (FCS) are discarded -> IDLE.
REQ-024 PAYLOAD end with fewer than 5 held (runt, 0 payload bytes emitted): no output -> IDLE.
REQ-025 CRC-32 (poly 0x04C11DB7, reflected, LSB-first, init 0xFFFFFFFF) runs over dst_mac..FCS; crc_bad = (register != 0xDEBB20E3) after the last FCS byte.
REQ-026 Byte counter (11 bits, dst..FCS): reaching MAX_FRAME+1 emits the oldest held byte with tlast=1, tuser=1, crc_err=1 -> DROP.
REQ-027 Latency: a payload byte appears on m_axis exactly 1 cycle after the 5th following byte is accepted, or 1 cycle after the gap.
REQ-028 m_axis_tvalid is never asserted outside a PAYLOAD-originated emit; tlast/tuser are 0 whenever tvalid=0.
REQ-029 Back-to-back frames with a 1-cycle gap SHALL both be received.

Reset
REQ-030 Reset -> state DROP, delay line empty, counters 0, CRC 0xFFFFFFFF, all outputs 0, hdr regs 0.
REQ-031 Reset mid-frame: no tlast for the aborted frame; the remainder is ignored until a gap.

Structure
REQ-032 Package eth_pkg: state enum, PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, CRC_INIT, CRC_RESIDUE 0xDEBB20E3, BCAST_MAC, header length 14.
REQ-033 Sub-module eth_crc32_d8 (combinational 8-bit CRC-32 next-state), shared with the transmit path.

Verification
REQ-034 Valid frame: 7x55, D5, dst=local_mac, 46-byte payload 00..2D, correct FCS -> 46 beats 00..2D, tlast on 2D, tuser=0, one hdr_valid.
REQ-035 Same frame with a payload byte flipped -> 46 beats, tlast tuser=1, crc_err pulse.
REQ-036 dst=02:00:00:00:00:99 (not local, PROMISC=0) -> no m_axis_tvalid, no hdr_valid; with dst=FF:..:FF -> accepted.
REQ-037 Preamble 4x55 then D5 -> DROP, no output; the next correct frame after a 1-cycle gap is received intact.
REQ-038 1600-byte frame with MAX_FRAME=1518 -> tlast, tuser=1 at the 1519th byte, then silence until the gap.
REQ-039 Reset asserted during payload byte 20 -> no tlast, outputs 0; the following frame is received correctly.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive/transmit datapaths.
// Pure declarations: no logic, no latency.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_DROP,
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_PAYLOAD
  } rx_state_e;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] eth_type;
  } hdr_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
  localparam int          HDR_LEN       = 14;
  localparam int          DLY_DEPTH     = 5;

endpackage

// File: rtl/eth_crc32_d8.sv
// Reflected CRC-32 next state for one byte, LSB first (IEEE 802.3 bit order).
// Purely combinational, zero latency; no flow control.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  always_comb begin
    crc_next = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC_POLY_REFL) : (crc_next >> 1);
    end
  end

endmodule

// File: rtl/eth_frame_rx.sv
// Ethernet frame receiver: strips preamble/SFD/header/FCS, filters dst MAC, checks CRC.
// Payload leaves 1 cycle after the 5th following byte (or the gap); no backpressure.
module eth_frame_rx
  import eth_pkg::*;
#(
  parameter int MAX_FRAME = 1518,
  parameter int PROMISC   = 0
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_areset,
  input  logic [47:0] local_mac,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [47:0] hdr_dst_mac,
  output logic [47:0] hdr_src_mac,
  output logic [15:0] hdr_eth_type,
  output logic        hdr_valid,
  output logic        crc_err
);

  localparam logic [10:0] MAX_CNT  = 11'(MAX_FRAME);
  localparam logic [2:0]  FULL     = 3'(DLY_DEPTH);
  localparam logic [3:0]  HDR_LAST = 4'(HDR_LEN - 1);

  rx_state_e   state, state_nxt;
  logic [2:0]  pre_cnt;
  logic [3:0]  hdr_cnt;
  logic [10:0] byte_cnt;
  logic [2:0]  held;
  logic [7:0]  dly [DLY_DEPTH];
  logic [8*(HDR_LEN-1)-1:0] hdr_sh;
  logic [31:0] crc, crc_next;
  hdr_t        hdr_full;
  logic        dst_ok, crc_bad;
  logic        emit, emit_last, emit_bad;

  eth_crc32_d8 u_crc (
    .crc      (crc),
    .data     (s_axis_tdata),
    .crc_next (crc_next)
  );

  // The 14th header byte completes the header in the same cycle it arrives.
  assign hdr_full = hdr_t'({hdr_sh, s_axis_tdata});
  assign dst_ok   = (PROMISC != 0) || (hdr_full.dst == local_mac) || (hdr_full.dst == BCAST_MAC);
  assign crc_bad  = (crc != CRC_RESIDUE);

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_last = 1'b0;
    emit_bad  = 1'b0;
    case (state)
      ST_DROP: begin
        if (!s_axis_tvalid) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (s_axis_tvalid)
          state_nxt = (s_axis_tdata == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
      end
      ST_PREAMBLE: begin
        if (!s_axis_tvalid)
          state_nxt = ST_IDLE;
        else if (s_axis_tdata == SFD_BYTE && pre_cnt >= 3'd6)
          state_nxt = ST_HEADER;
        else if (s_axis_tdata != PREAMBLE_BYTE)
          state_nxt = ST_DROP;
      end
      ST_HEADER: begin
        if (!s_axis_tvalid)
          state_nxt = ST_IDLE;
        else if (hdr_cnt == HDR_LAST)
          state_nxt = dst_ok ? ST_PAYLOAD : ST_DROP;
      end
      ST_PAYLOAD: begin
        if (!s_axis_tvalid) begin
          // Gap: the 4 youngest held bytes are the FCS and are discarded.
          state_nxt = ST_IDLE;
          if (held == FULL) begin
            emit      = 1'b1;
            emit_last = 1'b1;
            emit_bad  = crc_bad;
          end
        end else if (byte_cnt == MAX_CNT) begin
          state_nxt = ST_DROP;
          if (held == FULL) begin
            emit      = 1'b1;
            emit_last = 1'b1;
            emit_bad  = 1'b1;
          end
        end else if (held == FULL) begin
          emit = 1'b1;
        end
      end
      default: state_nxt = ST_DROP;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state         <= ST_DROP;
      pre_cnt       <= '0;
      hdr_cnt       <= '0;
      byte_cnt      <= '0;
      held          <= '0;
      crc           <= CRC_INIT;
      hdr_sh        <= '0;
      for (int i = 0; i < DLY_DEPTH; i++) dly[i] <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      crc_err       <= 1'b0;
      hdr_valid     <= 1'b0;
      hdr_dst_mac   <= '0;
      hdr_src_mac   <= '0;
      hdr_eth_type  <= '0;
    end else begin
      state         <= state_nxt;
      m_axis_tvalid <= emit;
      m_axis_tdata  <= emit ? dly[DLY_DEPTH-1] : '0;
      m_axis_tlast  <= emit_last;
      m_axis_tuser  <= emit_bad;
      crc_err       <= emit_bad;
      hdr_valid     <= 1'b0;
      if (s_axis_tvalid) begin
        case (state)
          ST_IDLE: pre_cnt <= 3'd1;
          ST_PREAMBLE: begin
            if (pre_cnt != 3'd7) pre_cnt <= pre_cnt + 3'd1;
            crc      <= CRC_INIT;
            hdr_cnt  <= '0;
            byte_cnt <= '0;
            held     <= '0;
          end
          ST_HEADER: begin
            crc      <= crc_next;
            byte_cnt <= byte_cnt + 11'd1;
            hdr_cnt  <= hdr_cnt + 4'd1;
            hdr_sh   <= {hdr_sh[8*(HDR_LEN-2)-1:0], s_axis_tdata};
            if (hdr_cnt == HDR_LAST && dst_ok) begin
              hdr_dst_mac  <= hdr_full.dst;
              hdr_src_mac  <= hdr_full.src;
              hdr_eth_type <= hdr_full.eth_type;
              hdr_valid    <= 1'b1;
            end
          end
          ST_PAYLOAD: begin
            crc      <= crc_next;
            byte_cnt <= byte_cnt + 11'd1;
            dly[0]   <= s_axis_tdata;
            for (int i = 1; i < DLY_DEPTH; i++) dly[i] <= dly[i-1];
            if (held != FULL) held <= held + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_rx.sv
// Directed bench for eth_frame_rx: good/bad-CRC/filtered/runt-preamble/oversize/reset-abort frames.
// Expected payload and FCS are built by the bench's own frame generator and bit-serial CRC.
module tb_eth_frame_rx;

  typedef logic [7:0] bq_t [$];

  localparam logic [47:0] LOCAL  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER  = 48'h02_00_00_00_00_99;
  localparam logic [47:0] BCAST  = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] SRC    = 48'h02_11_22_33_44_55;
  localparam logic [15:0] ETYPE  = 16'h0800;
  localparam int          PAY0   = 22;

  logic        s_axis_aclk = 1'b0;
  logic        s_axis_areset;
  logic [47:0] local_mac;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic [47:0] hdr_dst_mac, hdr_src_mac;
  logic [15:0] hdr_eth_type;
  logic        hdr_valid, crc_err;

  eth_frame_rx #(.MAX_FRAME(1518), .PROMISC(0)) dut (
    .s_axis_aclk   (s_axis_aclk),
    .s_axis_areset (s_axis_areset),
    .local_mac     (local_mac),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .hdr_dst_mac   (hdr_dst_mac),
    .hdr_src_mac   (hdr_src_mac),
    .hdr_eth_type  (hdr_eth_type),
    .hdr_valid     (hdr_valid),
    .crc_err       (crc_err)
  );

  always #5 s_axis_aclk = ~s_axis_aclk;

  int cyc = 0;
  always @(posedge s_axis_aclk) cyc <= cyc + 1;

  // Output monitor: cumulative record of everything the DUT emits.
  bq_t        got_q;
  int         beat_t [$];
  int         n_last = 0, n_hdrv = 0, n_crcerr = 0, n_side = 0, last_idx = -1;
  logic       last_user = 1'b0;
  logic [7:0] last_dat = 8'h00;

  always @(negedge s_axis_aclk) begin
    if (m_axis_tvalid === 1'b1) begin
      got_q.push_back(m_axis_tdata);
      beat_t.push_back(cyc);
      if (m_axis_tlast === 1'b1) begin
        n_last++;
        last_user = m_axis_tuser;
        last_dat  = m_axis_tdata;
        last_idx  = got_q.size() - 1;
      end
    end else if (m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0) begin
      n_side++;
    end
    if (hdr_valid === 1'b1) n_hdrv++;
    if (crc_err === 1'b1) n_crcerr++;
  end

  int n_cmp = 0, n_err = 0;
  int b_beats, b_last, b_hdrv, b_crc;
  int mark_cyc, gap_cyc;
  bq_t f, g;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_reg(input bq_t q);
    logic [31:0] c;
    logic [7:0]  d;
    c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      d = q[i];
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ d[b]) c = (c >> 1) ^ 32'hEDB8_8320;
        else             c = c >> 1;
      end
    end
    return c;
  endfunction

  // Preamble + SFD + header + payload(i & 0xFF) + FCS; optional payload bit flip after FCS.
  function automatic bq_t mk_frame(input logic [47:0] dst, input int npay, input int npre, input int flip);
    bq_t         body, fr;
    logic [31:0] fcs;
    for (int i = 0; i < 6; i++) body.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) body.push_back(SRC[47-8*i -: 8]);
    body.push_back(ETYPE[15:8]);
    body.push_back(ETYPE[7:0]);
    for (int i = 0; i < npay; i++) body.push_back(8'(i));
    fcs = ~crc_reg(body);
    for (int i = 0; i < 4; i++) body.push_back(fcs[8*i +: 8]);
    if (flip >= 0) body[14+flip] = body[14+flip] ^ 8'h01;
    for (int i = 0; i < npre; i++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    foreach (body[i]) fr.push_back(body[i]);
    return fr;
  endfunction

  task automatic send(input bq_t fr, input int mark, output int m_cyc, output int g_cyc);
    m_cyc = -1;
    foreach (fr[i]) begin
      @(negedge s_axis_aclk);
      s_axis_tdata  = fr[i];
      s_axis_tvalid = 1'b1;
      if (i == mark) m_cyc = cyc + 1;
    end
    @(negedge s_axis_aclk);
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    g_cyc = cyc + 1;
  endtask

  task automatic snap();
    b_beats = got_q.size();
    b_last  = n_last;
    b_hdrv  = n_hdrv;
    b_crc   = n_crcerr;
  endtask

  task automatic check_data(input string tag, input bq_t fr, input int n, input int base);
    int bad = 0;
    for (int i = 0; i < n; i++)
      if (base + i >= got_q.size() || got_q[base+i] !== fr[PAY0+i]) bad++;
    check(tag, bad, 0);
  endtask

  function automatic int beat_time(input int idx);
    return (idx >= 0 && idx < beat_t.size()) ? beat_t[idx] : -1;
  endfunction

  initial begin
    s_axis_areset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    local_mac     = LOCAL;
    repeat (3) @(negedge s_axis_aclk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_hdr_valid", hdr_valid, 0);
    check("rst_crc_err", crc_err, 0);
    check("rst_hdr_dst", hdr_dst_mac, 0);
    s_axis_areset = 1'b0;
    repeat (2) @(negedge s_axis_aclk);

    // Good unicast frame, 46-byte payload.
    f = mk_frame(LOCAL, 46, 7, -1);
    snap();
    send(f, PAY0 + 5, mark_cyc, gap_cyc);
    repeat (3) @(negedge s_axis_aclk);
    check("good_beats", got_q.size() - b_beats, 46);
    check_data("good_data", f, 46, b_beats);
    check("good_tlast_cnt", n_last - b_last, 1);
    check("good_tlast_dat", last_dat, 8'h2D);
    check("good_tuser", last_user, 0);
    check("good_crc_err", n_crcerr - b_crc, 0);
    check("good_hdr_valid", n_hdrv - b_hdrv, 1);
    check("good_hdr_dst", hdr_dst_mac, LOCAL);
    check("good_hdr_src", hdr_src_mac, SRC);
    check("good_hdr_type", hdr_eth_type, ETYPE);
    check("good_first_latency", beat_time(b_beats), mark_cyc);
    check("good_last_latency", beat_time(last_idx), gap_cyc);

    // Same frame with payload byte 10 corrupted.
    f = mk_frame(LOCAL, 46, 7, 10);
    snap();
    send(f, PAY0 + 5, mark_cyc, gap_cyc);
    repeat (3) @(negedge s_axis_aclk);
    check("badcrc_beats", got_q.size() - b_beats, 46);
    check_data("badcrc_data", f, 46, b_beats);
    check("badcrc_tlast_cnt", n_last - b_last, 1);
    check("badcrc_tuser", last_user, 1);
    check("badcrc_crc_err", n_crcerr - b_crc, 1);

    // Foreign unicast is filtered; broadcast is accepted.
    f = mk_frame(OTHER, 46, 7, -1);
    snap();
    send(f, PAY0 + 5, mark_cyc, gap_cyc);
    repeat (3) @(negedge s_axis_aclk);
    check("other_beats", got_q.size() - b_beats, 0);
    check("other_hdr_valid", n_hdrv - b_hdrv, 0);
    check("other_hdr_held", hdr_dst_mac, LOCAL);
    f = mk_frame(BCAST, 46, 7, -1);
    snap();
    send(f, PAY0 + 5, mark_cyc, gap_cyc);
    repeat (3) @(negedge s_axis_aclk);
    check("bcast_beats", got_q.size() - b_beats, 46);
    check("bcast_hdr_valid", n_hdrv - b_hdrv, 1);
    check("bcast_hdr_dst", hdr_dst_mac, BCAST);
    check("bcast_tuser", last_user, 0);

    // Short preamble is dropped; next frame after a single gap cycle is intact.
    f = mk_frame(LOCAL, 46, 4, -1);
    g = mk_frame(LOCAL, 46, 7, -1);
    snap();
    send(f, -1, mark_cyc, gap_cyc);
    send(g, PAY0 + 5, mark_cyc, gap_cyc);
    repeat (3) @(negedge s_axis_aclk);
    check("b2b_beats", got_q.size() - b_beats, 46);
    check_data("b2b_data", g, 46, b_beats);
    check("b2b_hdr_valid", n_hdrv - b_hdrv, 1);
    check("b2b_tlast_cnt", n_last - b_last, 1);
    check("b2b_tuser", last_user, 0);

    // 1600-byte frame: cut at byte 1519, payload bytes 0..1499 emitted.
    f = mk_frame(LOCAL, 1582, 7, -1);
    snap();
    send(f, PAY0 + 5, mark_cyc, gap_cyc);
    repeat (3) @(negedge s_axis_aclk);
    check("big_beats", got_q.size() - b_beats, 1500);
    check_data("big_data", f, 1500, b_beats);
    check("big_tlast_cnt", n_last - b_last, 1);
    check("big_tlast_pos", last_idx, b_beats + 1499);
    check("big_tlast_dat", last_dat, 8'hDB);
    check("big_tuser", last_user, 1);
    check("big_crc_err", n_crcerr - b_crc, 1);

    // Reset asserted with payload byte 20; rest of the frame must be ignored.
    f = mk_frame(LOCAL, 46, 7, -1);
    snap();
    for (int i = 0; i < f.size(); i++) begin
      @(negedge s_axis_aclk);
      if (i == PAY0 + 21) begin
        check("abort_tvalid", m_axis_tvalid, 0);
        check("abort_hdr_dst", hdr_dst_mac, 0);
      end
      s_axis_tdata  = f[i];
      s_axis_tvalid = 1'b1;
      s_axis_areset = (i == PAY0 + 20);
    end
    @(negedge s_axis_aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    repeat (3) @(negedge s_axis_aclk);
    check("abort_beats", got_q.size() - b_beats, 15);
    check_data("abort_data", f, 15, b_beats);
    check("abort_tlast_cnt", n_last - b_last, 0);
    g = mk_frame(LOCAL, 46, 7, -1);
    snap();
    send(g, PAY0 + 5, mark_cyc, gap_cyc);
    repeat (3) @(negedge s_axis_aclk);
    check("post_rst_beats", got_q.size() - b_beats, 46);
    check_data("post_rst_data", g, 46, b_beats);
    check("post_rst_tlast_cnt", n_last - b_last, 1);
    check("post_rst_tuser", last_user, 0);

    check("no_stray_tlast_tuser", n_side, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
